pipe_ctrl_fsm: RTL and testbench

Parametrised pipeline controller for the LoongArch core: merges per-stage stall requests into a pause vector, arbitrates commit-stage exceptions, interrupts and ERTN, and drives a registered multi-cycle flush with PC redirect. It adds an IDLE-wait state that holds the front of the pipe until an enabled interrupt arrives. It sits between the commit (mem/wb) stage, the CSR file and the PC/IF stages.

---
 rtl/pipe_ctrl_fsm.sv | 178 +++++++++++++++++
 tb/tb_pipe_ctrl_fsm.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl_fsm.sv
// rtl/pipe_ctrl_fsm.sv - pipeline stall/flush/exception controller with IDLE wait
module pipe_ctrl_fsm #(
  parameter int                   STAGES       = 6,
  parameter int                   EXC_SLOTS    = 5,
  parameter int                   CAUSE_W      = 7,
  parameter int                   INT_NUM      = 12,
  parameter logic [CAUSE_W-1:0]   INT_CAUSE    = 7'h00,
  parameter int                   FLUSH_CYCLES = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [STAGES-1:0]            stall_req_i,
  input  logic                         commit_valid_i,
  input  logic [31:0]                  commit_pc_i,
  input  logic [31:0]                  commit_badv_i,
  input  logic [EXC_SLOTS-1:0]         commit_exc_vec_i,
  input  logic [EXC_SLOTS*CAUSE_W-1:0] commit_exc_cause_i,
  input  logic                         commit_ertn_i,
  input  logic                         commit_idle_i,
  input  logic [31:0]                  csr_eentry_i,
  input  logic [31:0]                  csr_era_i,
  input  logic [INT_NUM-1:0]           csr_lie_i,
  input  logic [INT_NUM-1:0]           csr_is_i,
  input  logic                         csr_ie_i,
  output logic [STAGES-1:0]            pause_o,
  output logic                         flush_o,
  output logic                         redirect_valid_o,
  output logic [31:0]                  redirect_pc_o,
  output logic                         exc_valid_o,
  output logic [CAUSE_W-1:0]           exc_cause_o,
  output logic [31:0]                  exc_pc_o,
  output logic [31:0]                  exc_badv_o,
  output logic                         int_taken_o
);

  localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);

  typedef enum logic [1:0] {S_RUN, S_FLUSH, S_IDLE} state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [31:0]        idle_pc_q;
  logic               flush_q;
  logic               redirect_valid_q;
  logic [31:0]        redirect_pc_q;

  logic               int_pending;
  logic               exc_hit;
  logic [CAUSE_W-1:0] sel_cause;
  logic [STAGES-1:0]  stall_mask;
  logic               stall_acc;
  logic               take_d;
  logic               go_idle_d;
  logic [31:0]        target_d;
  logic [STAGES-1:0]  pause_d;
  logic               exc_valid_d;
  logic [CAUSE_W-1:0] exc_cause_d;
  logic [31:0]        exc_pc_d;
  logic [31:0]        exc_badv_d;
  logic               int_taken_d;

  always_comb begin
    int_pending = csr_ie_i & |(csr_lie_i & csr_is_i);
    exc_hit     = |commit_exc_vec_i;
    sel_cause   = '0;
    for (int i = 0; i < EXC_SLOTS; i++) begin
      if (commit_exc_vec_i[i]) sel_cause = commit_exc_cause_i[i*CAUSE_W +: CAUSE_W];
    end
    // Thermometer below the highest stalling stage: everything upstream holds too.
    stall_acc  = 1'b0;
    stall_mask = '0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      stall_acc     = stall_acc | stall_req_i[i];
      stall_mask[i] = stall_acc;
    end

    take_d      = 1'b0;
    go_idle_d   = 1'b0;
    target_d    = '0;
    pause_d     = '0;
    exc_valid_d = 1'b0;
    exc_cause_d = '0;
    exc_pc_d    = '0;
    exc_badv_d  = '0;
    int_taken_d = 1'b0;

    case (state_q)
      S_RUN: begin
        pause_d = stall_mask;
        if (commit_valid_i) begin
          if (exc_hit) begin
            take_d      = 1'b1;
            target_d    = csr_eentry_i;
            exc_valid_d = 1'b1;
            exc_cause_d = sel_cause;
            exc_pc_d    = commit_pc_i;
            exc_badv_d  = commit_badv_i;
          end else if (int_pending) begin
            take_d      = 1'b1;
            target_d    = csr_eentry_i;
            exc_valid_d = 1'b1;
            int_taken_d = 1'b1;
            exc_cause_d = INT_CAUSE;
            exc_pc_d    = commit_pc_i;
          end else if (commit_ertn_i) begin
            take_d   = 1'b1;
            target_d = csr_era_i;
          end else if (commit_idle_i) begin
            go_idle_d = 1'b1;
          end
        end
      end
      S_IDLE: begin
        pause_d = {1'b0, {(STAGES-1){1'b1}}};
        if (int_pending) begin
          take_d      = 1'b1;
          target_d    = csr_eentry_i;
          exc_valid_d = 1'b1;
          int_taken_d = 1'b1;
          exc_cause_d = INT_CAUSE;
          exc_pc_d    = idle_pc_q;
        end
      end
      default: ;
    endcase

    if (take_d) pause_d = '0;
  end

  // Combinational outputs are gated so an asserted reset silences them at once.
  assign pause_o          = rst ? '0 : pause_d;
  assign exc_valid_o      = rst ? 1'b0 : exc_valid_d;
  assign exc_cause_o      = rst ? '0 : exc_cause_d;
  assign exc_pc_o         = rst ? '0 : exc_pc_d;
  assign exc_badv_o       = rst ? '0 : exc_badv_d;
  assign int_taken_o      = rst ? 1'b0 : int_taken_d;
  assign flush_o          = flush_q;
  assign redirect_valid_o = redirect_valid_q;
  assign redirect_pc_o    = redirect_pc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= S_RUN;
      cnt_q            <= '0;
      idle_pc_q        <= '0;
      flush_q          <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
    end else begin
      redirect_valid_q <= 1'b0;
      case (state_q)
        S_RUN, S_IDLE: begin
          if (take_d) begin
            state_q          <= S_FLUSH;
            cnt_q            <= CNT_W'(FLUSH_CYCLES);
            flush_q          <= 1'b1;
            redirect_valid_q <= 1'b1;
            redirect_pc_q    <= target_d;
          end else if (go_idle_d) begin
            state_q   <= S_IDLE;
            idle_pc_q <= commit_pc_i + 32'd4;
          end
        end
        S_FLUSH: begin
          if (cnt_q <= CNT_W'(1)) begin
            state_q <= S_RUN;
            cnt_q   <= '0;
            flush_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: state_q <= S_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_ctrl_fsm.sv
// tb/tb_pipe_ctrl_fsm.sv - bench for pipe_ctrl_fsm, FLUSH_CYCLES=1 and =3 instances
module tb_pipe_ctrl_fsm;

  localparam logic [31:0] EENTRY = 32'h1c008000;
  localparam logic [31:0] ERA    = 32'h1c000100;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        cv;
  logic [31:0] pc, badv;
  logic [4:0]  evec;
  logic [34:0] ecause;
  logic        ertn, idle;
  logic [31:0] eentry, era;
  logic [11:0] lie, is_;
  logic        ie;

  logic [5:0]  o_pause [2];
  logic        o_flush [2];
  logic        o_rv    [2];
  logic [31:0] o_rpc   [2];
  logic        o_ev    [2];
  logic [6:0]  o_cause [2];
  logic [31:0] o_epc   [2];
  logic [31:0] o_badv  [2];
  logic        o_it    [2];

  int ncmp = 0;
  int nbad = 0;

  typedef struct {
    int          flush_left;
    bit          in_idle;
    logic [31:0] idle_pc;
    logic [31:0] rpc;
    bit          rfirst;
  } mst_t;
  mst_t m [2];
  int   fcs [2] = '{1, 3};

  typedef struct {
    logic [5:0]  stall;
    logic        cv;
    logic [4:0]  evec;
    logic        ertn;
    logic        intr;
    logic [31:0] pc;
    logic [5:0]  e_pause;
    logic        e_ev;
    logic [6:0]  e_cause;
    logic [31:0] e_epc;
    logic [31:0] e_badv;
    logic        e_it;
    logic        e_flush;
    logic [31:0] e_rpc;
  } vec_t;
  vec_t tv [7];

  always #5 clk = ~clk;

  pipe_ctrl_fsm #(.FLUSH_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .stall_req_i(stall), .commit_valid_i(cv),
    .commit_pc_i(pc), .commit_badv_i(badv), .commit_exc_vec_i(evec),
    .commit_exc_cause_i(ecause), .commit_ertn_i(ertn), .commit_idle_i(idle),
    .csr_eentry_i(eentry), .csr_era_i(era), .csr_lie_i(lie), .csr_is_i(is_),
    .csr_ie_i(ie), .pause_o(o_pause[0]), .flush_o(o_flush[0]),
    .redirect_valid_o(o_rv[0]), .redirect_pc_o(o_rpc[0]), .exc_valid_o(o_ev[0]),
    .exc_cause_o(o_cause[0]), .exc_pc_o(o_epc[0]), .exc_badv_o(o_badv[0]),
    .int_taken_o(o_it[0])
  );

  pipe_ctrl_fsm #(.FLUSH_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst), .stall_req_i(stall), .commit_valid_i(cv),
    .commit_pc_i(pc), .commit_badv_i(badv), .commit_exc_vec_i(evec),
    .commit_exc_cause_i(ecause), .commit_ertn_i(ertn), .commit_idle_i(idle),
    .csr_eentry_i(eentry), .csr_era_i(era), .csr_lie_i(lie), .csr_is_i(is_),
    .csr_ie_i(ie), .pause_o(o_pause[1]), .flush_o(o_flush[1]),
    .redirect_valid_o(o_rv[1]), .redirect_pc_o(o_rpc[1]), .exc_valid_o(o_ev[1]),
    .exc_cause_o(o_cause[1]), .exc_pc_o(o_epc[1]), .exc_badv_o(o_badv[1]),
    .int_taken_o(o_it[1])
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void mexp(input int j, output logic [5:0] p, output logic ev,
                               output logic [6:0] c, output logic [31:0] epc,
                               output logic [31:0] bv, output logic it, output logic take,
                               output logic [31:0] tgt, output logic gi);
    int   hi, k;
    logic ip;
    p = '0; ev = 0; c = '0; epc = '0; bv = '0; it = 0; take = 0; tgt = '0; gi = 0;
    ip = ie && ((lie & is_) != 12'd0);
    hi = -1;
    for (int i = 0; i < 5; i++) if (evec[i]) hi = i;
    k = -1;
    for (int i = 0; i < 6; i++) if (stall[i]) k = i;
    if (rst || m[j].flush_left > 0) return;
    if (m[j].in_idle) begin
      p = 6'b011111;
      if (ip) begin
        ev = 1; it = 1; c = 7'h00; epc = m[j].idle_pc; take = 1; tgt = eentry;
      end
      return;
    end
    p = (k < 0) ? 6'd0 : 6'((1 << (k + 1)) - 1);
    if (cv) begin
      if (hi >= 0) begin
        ev = 1; c = 7'((ecause >> (7 * hi)) & 35'h7f); epc = pc; bv = badv;
        take = 1; tgt = eentry;
      end else if (ip) begin
        ev = 1; it = 1; c = 7'h00; epc = pc; take = 1; tgt = eentry;
      end else if (ertn) begin
        take = 1; tgt = era;
      end else if (idle) begin
        gi = 1;
      end
    end
    if (take) p = '0;
  endfunction

  task automatic mzero();
    for (int j = 0; j < 2; j++) begin
      m[j].flush_left = 0; m[j].in_idle = 0; m[j].idle_pc = '0;
      m[j].rpc = '0; m[j].rfirst = 0;
    end
  endtask

  task automatic mcheck();
    logic [5:0] p; logic ev, it, take, gi; logic [6:0] c; logic [31:0] epc, bv, tgt;
    for (int j = 0; j < 2; j++) begin
      mexp(j, p, ev, c, epc, bv, it, take, tgt, gi);
      if (!(m[j].in_idle && take)) chk($sformatf("m%0d pause", j), 32'(o_pause[j]), 32'(p));
      chk($sformatf("m%0d exc_valid", j), 32'(o_ev[j]), 32'(ev));
      chk($sformatf("m%0d exc_cause", j), 32'(o_cause[j]), 32'(c));
      chk($sformatf("m%0d exc_pc", j), o_epc[j], epc);
      chk($sformatf("m%0d exc_badv", j), o_badv[j], bv);
      chk($sformatf("m%0d int_taken", j), 32'(o_it[j]), 32'(it));
      chk($sformatf("m%0d flush", j), 32'(o_flush[j]), 32'(m[j].flush_left > 0));
      chk($sformatf("m%0d redirect_valid", j), 32'(o_rv[j]), 32'(m[j].rfirst));
      chk($sformatf("m%0d redirect_pc", j), o_rpc[j], m[j].rpc);
    end
  endtask

  task automatic mupd();
    logic [5:0] p; logic ev, it, take, gi; logic [6:0] c; logic [31:0] epc, bv, tgt;
    if (rst) begin
      mzero();
      return;
    end
    for (int j = 0; j < 2; j++) begin
      mexp(j, p, ev, c, epc, bv, it, take, tgt, gi);
      if (m[j].flush_left > 0) begin
        m[j].flush_left--; m[j].rfirst = 0;
      end else if (take) begin
        m[j].flush_left = fcs[j]; m[j].rfirst = 1; m[j].rpc = tgt; m[j].in_idle = 0;
      end else begin
        m[j].rfirst = 0;
        if (gi) begin m[j].in_idle = 1; m[j].idle_pc = pc + 32'd4; end
      end
    end
  endtask

  // Called at the falling edge; returns just after the next rising edge.
  task automatic half();
    mcheck();
    @(posedge clk);
    mupd();
    #1;
  endtask

  task automatic tick();
    @(negedge clk);
    half();
  endtask

  task automatic clear();
    stall = '0; cv = 0; evec = '0; ertn = 0; idle = 0; ie = 0; lie = '0; is_ = '0; pc = '0;
  endtask

  task automatic settle();
    clear();
    repeat (4) tick();
  endtask

  initial begin
    tv[0] = '{6'b001100, 0, 5'b00000, 0, 0, 32'h0,        6'b001111, 0, 7'h00, 32'h0,        32'h0,        0, 0, 32'h0};
    tv[1] = '{6'b111111, 1, 5'b00110, 0, 0, 32'h1c000040, 6'b000000, 1, 7'h09, 32'h1c000040, 32'hbad00000, 0, 1, EENTRY};
    tv[2] = '{6'b000100, 1, 5'b00000, 1, 0, 32'h1c000080, 6'b000000, 0, 7'h00, 32'h0,        32'h0,        0, 1, ERA};
    tv[3] = '{6'b000011, 1, 5'b00000, 1, 1, 32'h1c000300, 6'b000000, 1, 7'h00, 32'h1c000300, 32'h0,        1, 1, EENTRY};
    tv[4] = '{6'b000000, 1, 5'b10001, 0, 1, 32'h1c000400, 6'b000000, 1, 7'h0b, 32'h1c000400, 32'hbad00000, 0, 1, EENTRY};
    tv[5] = '{6'b100000, 1, 5'b00000, 0, 0, 32'h1c000500, 6'b111111, 0, 7'h00, 32'h0,        32'h0,        0, 0, 32'h0};
    tv[6] = '{6'b000001, 0, 5'b00001, 1, 1, 32'h1c000600, 6'b000001, 0, 7'h00, 32'h0,        32'h0,        0, 0, 32'h0};

    mzero();
    // slot i cause = 7'h07 + i
    ecause = {7'h0b, 7'h0a, 7'h09, 7'h08, 7'h07};
    eentry = EENTRY; era = ERA; badv = 32'hbad00000;
    clear();
    rst = 1;
    stall = 6'b111111; cv = 1; evec = 5'b00001;
    #2;
    chk("reset pause", 32'(o_pause[0]), 32'h0);
    chk("reset exc_valid", 32'(o_ev[0]), 32'h0);
    chk("reset flush", 32'(o_flush[0]), 32'h0);
    chk("reset redirect_valid", 32'(o_rv[1]), 32'h0);
    chk("reset redirect_pc", o_rpc[0], 32'h0);
    clear();
    @(posedge clk); #1;
    rst = 0;
    tick();

    for (int v = 0; v < 7; v++) begin
      stall = tv[v].stall; cv = tv[v].cv; evec = tv[v].evec; ertn = tv[v].ertn;
      pc = tv[v].pc; ie = tv[v].intr; lie = tv[v].intr ? 12'h008 : 12'h0; is_ = lie;
      @(negedge clk);
      chk($sformatf("tv%0d pause", v), 32'(o_pause[0]), 32'(tv[v].e_pause));
      chk($sformatf("tv%0d exc_valid", v), 32'(o_ev[0]), 32'(tv[v].e_ev));
      chk($sformatf("tv%0d exc_cause", v), 32'(o_cause[0]), 32'(tv[v].e_cause));
      chk($sformatf("tv%0d exc_pc", v), o_epc[0], tv[v].e_epc);
      chk($sformatf("tv%0d exc_badv", v), o_badv[0], tv[v].e_badv);
      chk($sformatf("tv%0d int_taken", v), 32'(o_it[0]), 32'(tv[v].e_it));
      half();
      clear();
      @(negedge clk);
      chk($sformatf("tv%0d flush", v), 32'(o_flush[0]), 32'(tv[v].e_flush));
      chk($sformatf("tv%0d redirect_valid", v), 32'(o_rv[0]), 32'(tv[v].e_flush));
      if (tv[v].e_flush) chk($sformatf("tv%0d redirect_pc", v), o_rpc[0], tv[v].e_rpc);
      half();
      settle();
    end

    // IDLE wait, then wake on an enabled interrupt
    cv = 1; idle = 1; pc = 32'h1c000200;
    tick();
    clear();
    stall = 6'b100000;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle pause", 32'(o_pause[0]), 32'h1f);
      chk("idle exc_valid", 32'(o_ev[0]), 32'h0);
      half();
    end
    ie = 1; lie = 12'h008; is_ = 12'h008;
    @(negedge clk);
    chk("wake exc_valid", 32'(o_ev[0]), 32'h1);
    chk("wake int_taken", 32'(o_it[0]), 32'h1);
    chk("wake exc_pc", o_epc[0], 32'h1c000204);
    chk("wake exc_badv", o_badv[0], 32'h0);
    chk("wake exc_cause", 32'(o_cause[0]), 32'h0);
    half();
    clear();
    @(negedge clk);
    chk("wake flush", 32'(o_flush[0]), 32'h1);
    chk("wake redirect_pc", o_rpc[0], EENTRY);
    half();
    settle();

    // Three-cycle flush on the second instance
    cv = 1; evec = 5'b00001; pc = 32'h1c000700;
    @(negedge clk);
    chk("fc3 c0 exc_valid", 32'(o_ev[1]), 32'h1);
    half();
    clear();
    @(negedge clk);
    chk("fc3 c1 flush", 32'(o_flush[1]), 32'h1);
    chk("fc3 c1 redirect_valid", 32'(o_rv[1]), 32'h1);
    chk("fc3 c1 redirect_pc", o_rpc[1], EENTRY);
    half();
    @(negedge clk);
    chk("fc3 c2 flush", 32'(o_flush[1]), 32'h1);
    chk("fc3 c2 redirect_valid", 32'(o_rv[1]), 32'h0);
    half();
    cv = 1; evec = 5'b00010; pc = 32'h1c000800;
    @(negedge clk);
    chk("fc3 c3 flush", 32'(o_flush[1]), 32'h1);
    chk("fc3 c3 exc ignored", 32'(o_ev[1]), 32'h0);
    half();
    @(negedge clk);
    chk("fc3 c4 flush", 32'(o_flush[1]), 32'h0);
    chk("fc3 c4 exc accepted", 32'(o_ev[1]), 32'h1);
    chk("fc3 c4 exc_pc", o_epc[1], 32'h1c000800);
    chk("fc3 c4 exc_cause", 32'(o_cause[1]), 32'h08);
    half();
    clear();
    @(negedge clk);
    chk("fc3 c5 flush", 32'(o_flush[1]), 32'h1);
    chk("fc3 c5 redirect_valid", 32'(o_rv[1]), 32'h1);
    half();
    settle();

    // Asynchronous reset while parked in IDLE wait
    cv = 1; idle = 1; pc = 32'h1c000900;
    tick();
    clear();
    tick();
    tick();
    #2;
    rst = 1;
    mzero();
    #1;
    chk("async rst pause0", 32'(o_pause[0]), 32'h0);
    chk("async rst pause1", 32'(o_pause[1]), 32'h0);
    tick();
    rst = 0;
    cv = 1; evec = 5'b00100; pc = 32'h1c000a00;
    @(negedge clk);
    chk("post rst exc_valid", 32'(o_ev[0]), 32'h1);
    chk("post rst exc_pc", o_epc[0], 32'h1c000a00);
    half();
    clear();
    @(negedge clk);
    chk("post rst flush", 32'(o_flush[0]), 32'h1);
    half();
    settle();

    for (int n = 0; n < 1500; n++) begin
      stall = 6'($urandom);
      cv    = ($urandom_range(0, 1) == 1);
      evec  = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'd0;
      ecause = {3'($urandom), $urandom};
      ertn  = ($urandom_range(0, 3) == 0);
      idle  = ($urandom_range(0, 3) == 0);
      pc    = ($urandom_range(0, 15) == 0) ? 32'hfffffffc : $urandom;
      badv  = $urandom;
      ie    = ($urandom_range(0, 1) == 1);
      lie   = 12'($urandom);
      is_   = ($urandom_range(0, 7) == 0) ? 12'($urandom) : 12'd0;
      if ($urandom_range(0, 15) == 0) begin eentry = $urandom; era = $urandom; end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end

endmodule
